// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - descriptor layout, op encoding and FSM states for the SPI master arbiter
package spi_arb_pkg;

    localparam int DESC_W = 114;

    localparam int OP_LSB    = 0;   localparam int OP_W    = 2;
    localparam int CSREG_LSB = 2;   localparam int CSREG_W = 4;
    localparam int DUMMY_LSB = 6;   localparam int DUMMY_W = 16;
    localparam int DLEN_LSB  = 22;  localparam int DLEN_W  = 16;
    localparam int ALEN_LSB  = 38;  localparam int ALEN_W  = 6;
    localparam int ADDR_LSB  = 44;  localparam int ADDR_W  = 32;
    localparam int CLEN_LSB  = 76;  localparam int CLEN_W  = 6;
    localparam int CMD_LSB   = 82;  localparam int CMD_W   = 32;

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_QRD = 2'd2;
    localparam logic [1:0] OP_QWR = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_BUSY  = 2'd2;
    localparam state_t ST_GAP   = 2'd3;

    // Field order is MSB first, so a raw descriptor slice casts straight onto this struct.
    typedef struct packed {
        logic [CMD_W-1:0]   cmd;
        logic [CLEN_W-1:0]  cmd_len;
        logic [ADDR_W-1:0]  addr;
        logic [ALEN_W-1:0]  addr_len;
        logic [DLEN_W-1:0]  data_len;
        logic [DUMMY_W-1:0] dummy;
        logic [CSREG_W-1:0] csreg;
        logic [OP_W-1:0]    op;
    } desc_t;

endpackage

// File: rtl/spi_arb_rr.sv
// rtl/spi_arb_rr.sv - combinational round-robin picker, first request at or after ptr
module spi_arb_rr #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant
);

    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin front-end sharing one SPI master controller between requesters
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int GAP_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DESC_W-1:0] req_desc,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        req_done,
    input  logic [N_REQ*32-1:0]     req_tx_data,
    input  logic [N_REQ-1:0]        req_tx_valid,
    output logic [N_REQ-1:0]        req_tx_ready,
    output logic [31:0]             req_rx_data,
    output logic [N_REQ-1:0]        req_rx_valid,
    input  logic [N_REQ-1:0]        req_rx_ready,
    output logic                    busy,
    output logic [N_REQ-1:0]        grant,
    output logic [31:0]             spi_cmd,
    output logic [31:0]             spi_addr,
    output logic [5:0]              spi_cmd_len,
    output logic [5:0]              spi_addr_len,
    output logic [15:0]             spi_data_len,
    output logic [15:0]             spi_dummy_rd,
    output logic [15:0]             spi_dummy_wr,
    output logic [3:0]              spi_csreg,
    output logic                    spi_rd,
    output logic                    spi_wr,
    output logic                    spi_qrd,
    output logic                    spi_qwr,
    output logic [31:0]             spi_ctrl_data_tx,
    output logic                    spi_ctrl_data_tx_valid,
    input  logic                    spi_ctrl_data_tx_ready,
    input  logic [31:0]             spi_ctrl_data_rx,
    input  logic                    spi_ctrl_data_rx_valid,
    output logic                    spi_ctrl_data_rx_ready,
    input  logic                    eot
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CW-1:0] GAP_LOAD = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

    state_t         state_q, state_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  gap_cnt_q, gap_cnt_d;
    desc_t          cfg_q, cfg_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic           empty_done_q, empty_done_d;

    logic [N_REQ-1:0] pick;
    logic [PW-1:0]    pick_idx;
    desc_t            sel_desc;
    logic             accept, sel_empty, in_busy, in_start;

    spi_arb_rr #(.N_REQ(N_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick)
    );

    always_comb begin
        sel_desc = '0;
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                sel_desc = desc_t'(req_desc[i*DESC_W +: DESC_W]);
                pick_idx = PW'(i);
            end
        end
    end

    assign accept    = (state_q == ST_IDLE) && (|req_valid) && !rst;
    assign sel_empty = (sel_desc.cmd_len == '0) && (sel_desc.addr_len == '0) && (sel_desc.data_len == '0);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gap_cnt_d    = gap_cnt_q;
        cfg_d        = cfg_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        empty_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cfg_d    = sel_desc;
                    grant_d  = pick;
                    owner_d  = pick_idx;
                    rr_ptr_d = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    // A zero-length transfer would never see eot, so finish it here.
                    if (sel_empty) begin
                        state_d      = ST_GAP;
                        gap_cnt_d    = GAP_LOAD;
                        empty_done_d = 1'b1;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (eot) begin
                    if (GAP_CYC == 0) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            default: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            gap_cnt_q    <= '0;
            cfg_q        <= '0;
            grant_q      <= '0;
            owner_q      <= '0;
            empty_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gap_cnt_q    <= gap_cnt_d;
            cfg_q        <= cfg_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            empty_done_q <= empty_done_d;
        end
    end

    assign in_busy  = (state_q == ST_BUSY);
    assign in_start = (state_q == ST_START);

    assign req_ready = accept ? pick : '0;
    assign req_done  = ((in_busy && eot) || empty_done_q) ? grant_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign grant     = grant_q;

    assign spi_cmd      = cfg_q.cmd;
    assign spi_addr     = cfg_q.addr;
    assign spi_cmd_len  = cfg_q.cmd_len;
    assign spi_addr_len = cfg_q.addr_len;
    assign spi_data_len = cfg_q.data_len;
    assign spi_csreg    = cfg_q.csreg;
    // op[0] distinguishes write (1) from read (0) for both single and quad modes.
    assign spi_dummy_rd = cfg_q.op[0] ? '0 : cfg_q.dummy;
    assign spi_dummy_wr = cfg_q.op[0] ? cfg_q.dummy : '0;

    assign spi_rd  = in_start && (cfg_q.op == OP_RD);
    assign spi_wr  = in_start && (cfg_q.op == OP_WR);
    assign spi_qrd = in_start && (cfg_q.op == OP_QRD);
    assign spi_qwr = in_start && (cfg_q.op == OP_QWR);

    assign spi_ctrl_data_tx       = in_busy ? req_tx_data[owner_q*32 +: 32] : '0;
    assign spi_ctrl_data_tx_valid = in_busy && req_tx_valid[owner_q];
    assign req_tx_ready           = (in_busy && spi_ctrl_data_tx_ready) ? grant_q : '0;
    assign req_rx_data            = in_busy ? spi_ctrl_data_rx : '0;
    assign req_rx_valid           = (in_busy && spi_ctrl_data_rx_valid) ? grant_q : '0;
    assign spi_ctrl_data_rx_ready = in_busy && req_rx_ready[owner_q];

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - table-driven scoreboard bench for spi_master_arbiter
module tb_spi_master_arbiter;
    import spi_arb_pkg::*;

    localparam int N   = 2;
    localparam int GAP = 4;

    logic clk, rst;
    logic [N-1:0] req_valid, req_ready, req_done, req_tx_valid, req_tx_ready, req_rx_valid, req_rx_ready, grant;
    logic [N*DESC_W-1:0] req_desc;
    logic [N*32-1:0] req_tx_data;
    logic [31:0] req_rx_data, spi_cmd, spi_addr, spi_ctrl_data_tx, spi_ctrl_data_rx;
    logic [5:0]  spi_cmd_len, spi_addr_len;
    logic [15:0] spi_data_len, spi_dummy_rd, spi_dummy_wr;
    logic [3:0]  spi_csreg;
    logic busy, spi_rd, spi_wr, spi_qrd, spi_qwr, spi_ctrl_data_tx_valid, spi_ctrl_data_tx_ready;
    logic spi_ctrl_data_rx_valid, spi_ctrl_data_rx_ready, eot;

    spi_master_arbiter #(.N_REQ(N), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_desc(req_desc),
        .req_ready(req_ready), .req_done(req_done),
        .req_tx_data(req_tx_data), .req_tx_valid(req_tx_valid), .req_tx_ready(req_tx_ready),
        .req_rx_data(req_rx_data), .req_rx_valid(req_rx_valid), .req_rx_ready(req_rx_ready),
        .busy(busy), .grant(grant), .spi_cmd(spi_cmd), .spi_addr(spi_addr),
        .spi_cmd_len(spi_cmd_len), .spi_addr_len(spi_addr_len), .spi_data_len(spi_data_len),
        .spi_dummy_rd(spi_dummy_rd), .spi_dummy_wr(spi_dummy_wr), .spi_csreg(spi_csreg),
        .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_qrd(spi_qrd), .spi_qwr(spi_qwr),
        .spi_ctrl_data_tx(spi_ctrl_data_tx), .spi_ctrl_data_tx_valid(spi_ctrl_data_tx_valid),
        .spi_ctrl_data_tx_ready(spi_ctrl_data_tx_ready), .spi_ctrl_data_rx(spi_ctrl_data_rx),
        .spi_ctrl_data_rx_valid(spi_ctrl_data_rx_valid), .spi_ctrl_data_rx_ready(spi_ctrl_data_rx_ready),
        .eot(eot)
    );

    typedef struct {
        int          r;
        logic [1:0]  op;
        logic [31:0] cmd;
        logic [5:0]  cmd_len;
        logic [31:0] addr;
        logic [5:0]  addr_len;
        logic [15:0] data_len;
        logic [15:0] dummy;
        logic [3:0]  csreg;
        logic [3:0]  exp_strobe;
        logic [15:0] exp_drd;
        logic [15:0] exp_dwr;
        bit          exp_empty;
        logic [31:0] word;
    } vec_t;

    vec_t tbl[5];
    vec_t fv[2];
    vec_t sb[$];

    int checks = 0, errors = 0;
    int cyc = 0, last_eot_cyc = 0, strobe_cnt = 0;
    bit have_eot = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DESC_W-1:0] pack_desc(input vec_t v);
        logic [DESC_W-1:0] d;
        d = '0;
        d[1:0]    = v.op;
        d[5:2]    = v.csreg;
        d[21:6]   = v.dummy;
        d[37:22]  = v.data_len;
        d[43:38]  = v.addr_len;
        d[75:44]  = v.addr;
        d[81:76]  = v.cmd_len;
        d[113:82] = v.cmd;
        return d;
    endfunction

    function automatic logic [N-1:0] oh(input int r);
        logic [N-1:0] t;
        t = '0;
        t[r] = 1'b1;
        return t;
    endfunction

    // Strobe monitor: one-hot strobes, and eot-to-strobe spacing of at least GAP+2 cycles.
    always @(negedge clk) begin
        #2;
        if (!rst && (spi_rd || spi_wr || spi_qrd || spi_qwr)) begin
            strobe_cnt++;
            check("strobe_onehot", 64'($countones({spi_rd, spi_wr, spi_qrd, spi_qwr})), 64'd1);
            if (have_eot) begin
                checks++;
                if (cyc - last_eot_cyc < GAP + 2) begin
                    errors++;
                    $display("FAIL strobe_gap: got %0d cycles expected at least %0d", cyc - last_eot_cyc, GAP + 2);
                end
            end
        end
    end

    task automatic wait_ready(output bit got);
        got = 1'b0;
        for (int w = 0; w < 40; w++) begin
            #1;
            if (|req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_txn(input vec_t v, input bit keep, input logic [N-1:0] extra);
        vec_t e;
        bit got;
        int nw;
        strobe_cnt = 0;
        @(negedge clk);
        req_desc[v.r*DESC_W +: DESC_W] = pack_desc(v);
        req_valid = req_valid | extra | oh(v.r);
        wait_ready(got);
        if (!got) begin
            req_valid = '0;
            return;
        end
        check("req_ready", 64'(req_ready), 64'(oh(v.r)));
        sb.push_back(v);
        @(negedge clk);
        if (!keep) req_valid[v.r] = 1'b0;
        #1;
        e = sb.pop_front();
        if (e.exp_empty) begin
            check("empty_done", 64'(req_done), 64'(oh(e.r)));
            check("empty_no_strobe", 64'({spi_qwr, spi_qrd, spi_wr, spi_rd}), 64'd0);
            for (int i = 1; i < GAP; i++) begin
                @(negedge clk); #1;
                check("empty_gap_busy", 64'({busy, req_done}), 64'({1'b1, {N{1'b0}}}));
            end
            @(negedge clk); #1;
            check("empty_gap_exit", 64'(busy), 64'd0);
            check("empty_strobe_cnt", 64'(strobe_cnt), 64'd0);
            return;
        end
        check("strobe", 64'({spi_qwr, spi_qrd, spi_wr, spi_rd}), 64'(e.exp_strobe));
        check("grant", 64'(grant), 64'(oh(e.r)));
        check("dummy_rd", 64'(spi_dummy_rd), 64'(e.exp_drd));
        check("dummy_wr", 64'(spi_dummy_wr), 64'(e.exp_dwr));
        check("cfg_cmd", 64'(spi_cmd), 64'(e.cmd));
        check("cfg_addr", 64'(spi_addr), 64'(e.addr));
        check("cfg_lens", 64'({spi_cmd_len, spi_addr_len, spi_data_len, spi_csreg}),
              64'({e.cmd_len, e.addr_len, e.data_len, e.csreg}));
        nw = (e.op == OP_QWR) ? 2 : 1;
        for (int k = 0; k < nw; k++) begin
            @(negedge clk);
            if (!e.op[0]) begin
                spi_ctrl_data_rx = e.word + 32'(k);
                spi_ctrl_data_rx_valid = 1'b1;
                req_rx_ready = oh(e.r);
                #1;
                check("rx_valid_route", 64'(req_rx_valid), 64'(oh(e.r)));
                check("rx_data", 64'(req_rx_data), 64'(e.word + 32'(k)));
                check("rx_ready_up", 64'(spi_ctrl_data_rx_ready), 64'd1);
            end else begin
                req_tx_data[e.r*32 +: 32] = e.word + 32'(k);
                req_tx_valid[e.r] = 1'b1;
                spi_ctrl_data_tx_ready = 1'b1;
                #1;
                check("tx_data", 64'(spi_ctrl_data_tx), 64'(e.word + 32'(k)));
                check("tx_valid", 64'(spi_ctrl_data_tx_valid), 64'd1);
                check("tx_ready_route", 64'(req_tx_ready), 64'(oh(e.r)));
            end
        end
        @(negedge clk);
        spi_ctrl_data_rx_valid = 1'b0;
        req_rx_ready = '0;
        req_tx_valid = '0;
        spi_ctrl_data_tx_ready = 1'b0;
        eot = 1'b1;
        last_eot_cyc = cyc;
        have_eot = 1'b1;
        #1;
        check("done_on_eot", 64'(req_done), 64'(oh(e.r)));
        @(negedge clk);
        eot = 1'b0;
        #1;
        check("done_single", 64'(req_done), 64'd0);
        check("gap_busy_cfg_held", 64'({busy, spi_cmd}), 64'({1'b1, e.cmd}));
        check("strobe_once", 64'(strobe_cnt), 64'd1);
    endtask

    initial begin
        bit got;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit got;
        tbl[0] = '{r:0, op:OP_RD,  cmd:32'h0B, cmd_len:6'd8, addr:32'h1000, addr_len:6'd24, data_len:16'd32,
                   dummy:16'd8, csreg:4'h1, exp_strobe:4'b0001, exp_drd:16'd8, exp_dwr:16'd0, exp_empty:0, word:32'hA5A50001};
        tbl[1] = '{r:1, op:OP_QWR, cmd:32'h32, cmd_len:6'd8, addr:32'h2000, addr_len:6'd24, data_len:16'd64,
                   dummy:16'd4, csreg:4'h2, exp_strobe:4'b1000, exp_drd:16'd0, exp_dwr:16'd4, exp_empty:0, word:32'hDEADBEEF};
        tbl[2] = '{r:0, op:OP_WR,  cmd:32'h02, cmd_len:6'd8, addr:32'h0030, addr_len:6'd24, data_len:16'd16,
                   dummy:16'd0, csreg:4'h4, exp_strobe:4'b0010, exp_drd:16'd0, exp_dwr:16'd0, exp_empty:0, word:32'h12345678};
        tbl[3] = '{r:1, op:OP_QRD, cmd:32'h6B, cmd_len:6'd8, addr:32'h0040, addr_len:6'd24, data_len:16'd32,
                   dummy:16'd6, csreg:4'h8, exp_strobe:4'b0100, exp_drd:16'd6, exp_dwr:16'd0, exp_empty:0, word:32'h0BADF00D};
        tbl[4] = '{r:0, op:OP_RD,  cmd:32'h99, cmd_len:6'd0, addr:32'h0000, addr_len:6'd0,  data_len:16'd0,
                   dummy:16'd3, csreg:4'h1, exp_strobe:4'b0000, exp_drd:16'd3, exp_dwr:16'd0, exp_empty:1, word:32'h0};
        fv[0]  = '{r:0, op:OP_RD,  cmd:32'h03, cmd_len:6'd8, addr:32'h0100, addr_len:6'd24, data_len:16'd8,
                   dummy:16'd0, csreg:4'h1, exp_strobe:4'b0001, exp_drd:16'd0, exp_dwr:16'd0, exp_empty:0, word:32'h11110000};
        fv[1]  = '{r:1, op:OP_RD,  cmd:32'h0B, cmd_len:6'd8, addr:32'h0200, addr_len:6'd24, data_len:16'd8,
                   dummy:16'd2, csreg:4'h2, exp_strobe:4'b0001, exp_drd:16'd2, exp_dwr:16'd0, exp_empty:0, word:32'h22220000};

        rst = 1'b1; eot = 1'b0;
        req_valid = '0; req_desc = '0; req_tx_data = '0; req_tx_valid = '0; req_rx_ready = '0;
        spi_ctrl_data_tx_ready = 1'b0; spi_ctrl_data_rx = '0; spi_ctrl_data_rx_valid = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_outs", 64'(|{req_ready, req_done, req_tx_ready, req_rx_valid, spi_cmd, spi_addr, spi_cmd_len,
              spi_addr_len, spi_data_len, spi_dummy_rd, spi_dummy_wr, spi_csreg, spi_rd, spi_wr, spi_qrd, spi_qwr,
              spi_ctrl_data_tx, spi_ctrl_data_tx_valid, spi_ctrl_data_rx_ready}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) do_txn(tbl[i], 1'b0, '0);

        // Abort three cycles into BUSY; requester 0 is used so rr_ptr would be 1 without reset.
        @(negedge clk);
        req_desc[0 +: DESC_W] = pack_desc(fv[0]);
        req_valid = 2'b01;
        wait_ready(got);
        @(negedge clk); req_valid = '0;
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        check("pre_rst_busy", 64'(busy), 64'd1);
        spi_ctrl_data_rx_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk); #1;
        check("abort_done", 64'(req_done), 64'd0);
        check("abort_busy_grant", 64'({busy, grant}), 64'd0);
        check("abort_outs", 64'(|{req_ready, req_tx_ready, req_rx_valid, req_rx_data, spi_cmd, spi_addr,
              spi_cmd_len, spi_addr_len, spi_data_len, spi_dummy_rd, spi_dummy_wr, spi_csreg,
              spi_rd, spi_wr, spi_qrd, spi_qwr, spi_ctrl_data_tx_valid, spi_ctrl_data_rx_ready}), 64'd0);
        rst = 1'b0;
        spi_ctrl_data_rx_valid = 1'b0;
        have_eot = 1'b0;

        // Both requesters held valid: grants must start at 0 after reset and alternate.
        req_desc[0 +: DESC_W]      = pack_desc(fv[0]);
        req_desc[DESC_W +: DESC_W] = pack_desc(fv[1]);
        begin
            int exp_ptr;
            exp_ptr = 0;
            for (int k = 0; k < 4; k++) begin
                do_txn(fv[exp_ptr], 1'b1, 2'b11);
                exp_ptr = (exp_ptr + 1) % N;
            end
        end
        req_valid = '0;
        repeat (GAP + 2) @(negedge clk);
        #1;
        check("final_idle", 64'(busy), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Sequencing front-end that shares one `spi_master_controller` between `N_REQ` requesters (boot loader, DMA, CPU register path). Each requester submits a transaction descriptor with a valid/ready handshake. The block grants one requester at a time using round-robin priority, programs the controller's config inputs, issues the single-cycle op strobe and routes the TX/RX data streams to the owner until `eot`. It then enforces a minimum chip-select idle gap before the next grant.

## Interface
Parameters
- `N_REQ`, 2: number of requesters, 2..4.
- `GAP_CYC`, 4: minimum clk cycles between `eot` and the next strobe; 0 allowed.

Ports
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  descriptor valid, one bit per requester.
- `req_desc`  in  N_REQ*DESC_W  packed descriptors; requester i at `[i*DESC_W +: DESC_W]`.
- `req_ready`  out  N_REQ  descriptor accepted; one-hot pulse.
- `req_done`  out  N_REQ  one-cycle pulse to the owner when its transaction ends.
- `req_tx_data` / `req_tx_valid` / `req_tx_ready`  in/in/out  N_REQ*32 / N_REQ / N_REQ  per-requester TX stream.
- `req_rx_data` / `req_rx_valid` / `req_rx_ready`  out/out/in  32 / N_REQ / N_REQ  RX stream; data is shared, valid is demuxed.
- `busy`  out  1  a transaction is in flight (START, BUSY or GAP).
- `grant`  out  N_REQ  one-hot current owner; all zero when idle.
- `spi_cmd`, `spi_addr`  out  32  to controller.
- `spi_cmd_len`, `spi_addr_len`  out  6  to controller.
- `spi_data_len`, `spi_dummy_rd`, `spi_dummy_wr`  out  16  to controller.
- `spi_csreg`  out  4  to controller.
- `spi_rd`, `spi_wr`, `spi_qrd`, `spi_qwr`  out  1  op strobes to controller.
- `spi_ctrl_data_tx`, `spi_ctrl_data_tx_valid`  out  32, 1  to controller.
- `spi_ctrl_data_tx_ready`  in  1  from controller.
- `spi_ctrl_data_rx`, `spi_ctrl_data_rx_valid`  in  32, 1  from controller.
- `spi_ctrl_data_rx_ready`  out  1  to controller.
- `eot`  in  1  end-of-transfer pulse from controller.

## Operation
- Descriptor fields, LSB first:
  - `op[1:0]`: 0 = rd, 1 = wr, 2 = qrd, 3 = qwr.
  - `csreg[3:0]`, `dummy[15:0]`, `data_len[15:0]`, `addr_len[5:0]`, `addr[31:0]`, `cmd_len[5:0]`, `cmd[31:0]`.
  - DESC_W = 114.
- FSM states IDLE, START, BUSY, GAP.
- IDLE
  - If any `req_valid` is set, the round-robin picker chooses the first requester at or after `rr_ptr`.
  - The chosen `req_ready` is asserted that cycle, and the descriptor is latched into config registers at the edge.
  - `rr_ptr` becomes grant+1 mod N_REQ.
  - Next state is START. If `cmd_len`, `addr_len` and `data_len` are all zero, no strobe is issued (the controller would never `eot`): the owner's `req_done` pulses on the next cycle and the FSM goes to GAP.
- START
  - Exactly one strobe selected by `op` is high for one cycle.
  - `dummy` is driven to `spi_dummy_rd` for rd/qrd and to `spi_dummy_wr` for wr/qwr; the other dummy output is 0.
  - Next state is BUSY.
- BUSY
  - The granted requester's TX and RX streams are muxed to and from the controller.
  - Non-granted `req_tx_ready` and `req_rx_valid` are held at 0.
  - On `eot`: the owner's `req_done` pulses the same cycle, and the FSM goes to GAP, or to IDLE if GAP_CYC = 0.
- GAP
  - A down-counter loaded with GAP_CYC-1 runs; the FSM goes to IDLE when it reaches 0.
  - Streams are not routed.
- Config outputs hold their latched values from the IDLE accept until the next accept. The controller samples the lengths in its later states, so they must stay stable.
- `req_valid` arriving in BUSY or GAP waits; `req_desc` must stay stable while valid and not yet ready.

## Timing
- Reset: state IDLE, `rr_ptr` = 0, gap counter = 0.
- Reset value of every output is 0: `req_ready`, `req_done`, `busy`, `grant`, all `spi_*` outputs, strobes and streams.
- `rst` mid-transaction aborts to IDLE with no `req_done`. `rst` must be applied together with the controller's reset.
- Accept to strobe: 1 cycle (accept edge, then START). Strobe to first possible `eot`: controller-defined.
- `eot` to next strobe is at least GAP_CYC+2 cycles.
- With simultaneous `req_valid` on all requesters, grants rotate 0, 1, …, N_REQ-1, 0.
- An `eot` outside BUSY is ignored.
- A requester dropping `req_valid` before ready loses no state.

## Structure
- Package `spi_arb_pkg` holds:
  - DESC_W and the field offsets/widths.
  - The op encoding.
  - The FSM state enum.
- Sub-module `spi_arb_rr`: combinational round-robin picker taking `req`, `ptr` and `N_REQ`, returning a one-hot grant.
- Top level contains the FSM, config registers, gap counter and stream mux.

## Test plan
- Single read: req0 `op`=0, cmd 0x0B/8, addr 0x1000/24, `data_len` 32, `dummy` 8.
  - `spi_rd` is high exactly once, `spi_dummy_rd` = 8, `spi_dummy_wr` = 0.
  - RX word reaches req0 only; `req_done[0]` pulses on `eot`.
- Fairness: req0 and req1 held valid continuously, N_REQ = 2.
  - Grants alternate 0, 1, 0, 1 over 4 transactions.
  - Strobe spacing after each `eot` is at least GAP_CYC+2 = 6 cycles.
- Quad write from req1: `op`=3, `data_len` 64, two TX words.
  - `spi_qwr` pulses once; `req_tx_ready[0]` stays 0 throughout.
- Empty descriptor (all lens 0).
  - No strobe; `req_done` pulses 1 cycle after `req_ready`; FSM passes through GAP.
- `rst` asserted 3 cycles into BUSY.
  - Next cycle all outputs are 0, no `req_done`, and `rr_ptr` = 0.
  - The next request is granted normally.
